div_multi: RTL
==============

// Module: div_multi
// PURPOSE
//  Parametrised iterative integer divider for the EX stage. Executes RISC-V M-extension
//  DIV/DIVU/REM/REMU at XLEN width, retiring BITS_PER_CYCLE quotient bits per cycle.
//  Latches operands on a one-cycle start handshake, so start_i need not be held.
//  Supports a pipeline flush that aborts an operation, and single-cycle special-case results.
// PARAMETERS
//  XLEN            32  operand/result width; must be a multiple of BITS_PER_CYCLE
//  BITS_PER_CYCLE  1   radix-2 steps per cycle: 1, 2 or 4
//  REG_ADDR_W      5   destination register address width
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous active-high reset
//  dividend_i   in   XLEN        dividend (rs1)
//  divisor_i    in   XLEN        divisor (rs2)
//  start_i      in   1           start request; accepted when state is IDLE or DONE
//  op_i         in   3           funct3: DIV=100, DIVU=101, REM=110, REMU=111
//  reg_waddr_i  in   REG_ADDR_W  destination register
//  flush_i      in   1           abort the operation in flight
//  result_o     out  XLEN        quotient (DIV/DIVU) or remainder (REM/REMU)
//  ready_o      out  1           result valid; one-cycle pulse
//  busy_o       out  1           operation in flight
//  reg_waddr_o  out  REG_ADDR_W  destination register, registered with the result
// BEHAVIOUR
//  - Reset: synchronous on rst=1. State returns to IDLE. result_o, ready_o, busy_o and reg_waddr_o go to 0.
//  - States:
//      IDLE -> CALC on accepted start.
//      IDLE -> DONE directly for a special case.
//      CALC runs N = XLEN/BITS_PER_CYCLE cycles, then -> FIX.
//      FIX (1 cycle, sign correction) -> DONE.
//      DONE -> IDLE, or -> CALC/DONE if a new start is accepted in that cycle.
//  - Outputs: busy_o = state in {CALC, FIX}. ready_o = state is DONE. All outputs are registered.
//  - Latency, from the start-accept edge to the ready_o rising edge:
//      normal operation: N+2 edges (34 at the defaults);
//      special cases: 1 edge.
//  - Operand capture: op, reg_waddr and operands are captured at accept. Input changes afterwards are ignored.
//  - Signed ops: operate on magnitudes.
//      Quotient is negated when the operand signs differ.
//      Remainder takes the dividend's sign.
//  - Divide by zero: quotient = all ones; remainder = dividend.
//  - Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend; remainder = 0.
//  - start_i while busy_o=1: ignored; no queueing.
//  - flush_i=1 at an edge: state -> IDLE; busy_o=0 and ready_o=0 from the next cycle.
//      A result already on ready_o in the current cycle is not retracted.
//      flush_i and start_i together: flush wins and the start is dropped.
//  - result_o and reg_waddr_o hold their values after DONE until the next result is written.
// CONFIGURATION
//  - DIV_EARLY_OUT_EN defined:
//      At accept, if |dividend| < |divisor| (unsigned compare of magnitudes), go straight to DONE.
//      Result: quotient 0; remainder = dividend. Latency 1.
//      The same check takes the 1-cycle path when dividend = 0.
//  - DIV_EARLY_OUT_EN undefined: these cases take the full N+2 path. Results are identical either way.
// STRUCTURE
//  - Package div_pkg holds:
//      op encodings DIV_OP_DIV/DIVU/REM/REMU;
//      state enum div_state_e {IDLE, CALC, FIX, DONE};
//      the helper is_signed_op().
//  - Sub-module div_step: combinational restoring step.
//      Inputs: partial remainder, divisor, next dividend bit.
//      Outputs: new remainder, quotient bit.
//      Instantiated BITS_PER_CYCLE times in a chain.
//  - Iteration counter width: $clog2(N+1).
// TESTING
//  1. DIV 15/3, reg 12, defaults -> ready_o at edge 34 after accept; result_o=5; reg_waddr_o=12; busy_o high 33 cycles.
//  2. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. REMU 0xFFFFFFF9/2 -> 1.
//  3. DIVU 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all 1-cycle latency.
//  4. flush_i at cycle 10 of CALC, then start on the next cycle with DIV 20/4 -> no stale ready; result 5 at N+2.
//  5. BITS_PER_CYCLE=4, DIVU 1000/7 -> result 142 at edge 10. 500 random vectors at BPC 1/2/4 vs a reference model.
//  6. DIV_EARLY_OUT_EN set, REMU 3/10 -> 3 at edge 1. Back-to-back start in the DONE cycle is accepted.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: funct3 encodings, FSM states, op decode helpers.
package div_pkg;

  localparam logic [2:0] DIV_OP_DIV  = 3'b100;
  localparam logic [2:0] DIV_OP_DIVU = 3'b101;
  localparam logic [2:0] DIV_OP_REM  = 3'b110;
  localparam logic [2:0] DIV_OP_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_multi_step.sv
// One restoring radix-2 division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quo_o
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // Trial subtraction; the partial remainder is always below the divisor, so XLEN+1 bits suffice.
  always_comb begin
    shifted_s = {rem_i, bit_i};
    diff_s    = shifted_s - {1'b0, divisor_i};
    quo_o     = (shifted_s >= {1'b0, divisor_i});
    if (quo_o) begin
      rem_o = diff_s[XLEN-1:0];
    end else begin
      rem_o = shifted_s[XLEN-1:0];
    end
  end

endmodule

// File: rtl/div_multi.sv
// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU), BITS_PER_CYCLE quotient bits per cycle.
// Optional feature macro: DIV_EARLY_OUT_EN (single-cycle result when |dividend| < |divisor|).
module div_multi
  import div_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned REG_ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       dividend_i,
  input  logic [XLEN-1:0]       divisor_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  flush_i,
  output logic [XLEN-1:0]       result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o
);

  localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ZERO_W   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES_W   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  rem_op_q, rem_op_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic                  busy_q, busy_d, ready_q, ready_d;
  logic [REG_ADDR_W-1:0] waddr_pend_q, waddr_pend_d, waddr_q, waddr_d;

  logic                  sgn_s, rem_op_s, div_zero_s, ovf_s, early_s, special_s;
  logic [XLEN-1:0]       dvd_mag_s, dvs_mag_s, special_res_s;

  logic [XLEN-1:0]       rem_chain_s [BITS_PER_CYCLE+1];
  logic [XLEN-1:0]       quo_chain_s [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] qbit_s;

  assign rem_chain_s[0] = rem_q;
  assign quo_chain_s[0] = quo_q;

  // Quotient bits leave the top of quo and re-enter at the bottom, so quo ends up holding the quotient.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_chain_s[i]),
      .divisor_i (dvsr_q),
      .bit_i     (quo_chain_s[i][XLEN-1]),
      .rem_o     (rem_chain_s[i+1]),
      .quo_o     (qbit_s[i])
    );
    assign quo_chain_s[i+1] = {quo_chain_s[i][XLEN-2:0], qbit_s[i]};
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_s = (dvd_mag_s < dvs_mag_s);
`else
  assign early_s = 1'b0;
`endif

  // Operand decode at accept: magnitudes and the single-cycle special cases.
  always_comb begin
    sgn_s      = is_signed_op(op_i);
    rem_op_s   = is_rem_op(op_i);
    dvd_mag_s  = (sgn_s && dividend_i[XLEN-1]) ? neg_f(dividend_i) : dividend_i;
    dvs_mag_s  = (sgn_s && divisor_i[XLEN-1])  ? neg_f(divisor_i)  : divisor_i;
    div_zero_s = (divisor_i == ZERO_W);
    ovf_s      = sgn_s && (dividend_i == MIN_NEG) && (divisor_i == ONES_W);
    special_s  = div_zero_s || ovf_s || early_s;
    if (div_zero_s) begin
      special_res_s = rem_op_s ? dividend_i : ONES_W;
    end else if (ovf_s) begin
      special_res_s = rem_op_s ? ZERO_W : dividend_i;
    end else begin
      special_res_s = rem_op_s ? dividend_i : ZERO_W;
    end
  end

  // FSM next state and datapath updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    result_d     = result_q;
    rem_op_d     = rem_op_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    waddr_pend_d = waddr_pend_q;
    waddr_d      = waddr_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            if (special_s) begin
              state_d  = DONE;
              result_d = special_res_s;
              waddr_d  = reg_waddr_i;
            end else begin
              state_d      = CALC;
              cnt_d        = CNT_LOAD;
              rem_d        = ZERO_W;
              quo_d        = dvd_mag_s;
              dvsr_d       = dvs_mag_s;
              rem_op_d     = rem_op_s;
              neg_quo_d    = sgn_s && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
              neg_rem_d    = sgn_s && dividend_i[XLEN-1];
              waddr_pend_d = reg_waddr_i;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          rem_d = rem_chain_s[BITS_PER_CYCLE];
          quo_d = quo_chain_s[BITS_PER_CYCLE];
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
        FIX: begin
          if (rem_op_q) begin
            result_d = neg_rem_q ? neg_f(rem_q) : rem_q;
          end else begin
            result_d = neg_quo_q ? neg_f(quo_q) : quo_q;
          end
          waddr_d = waddr_pend_q;
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d  = (state_d == CALC) || (state_d == FIX);
    ready_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      rem_q        <= ZERO_W;
      quo_q        <= ZERO_W;
      dvsr_q       <= ZERO_W;
      result_q     <= ZERO_W;
      rem_op_q     <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      waddr_pend_q <= {REG_ADDR_W{1'b0}};
      waddr_q      <= {REG_ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvsr_q       <= dvsr_d;
      result_q     <= result_d;
      rem_op_q     <= rem_op_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      waddr_pend_q <= waddr_pend_d;
      waddr_q      <= waddr_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign reg_waddr_o = waddr_q;

endmodule
